// File: rtl/cv32e40p_apu_responder_if.sv
// rtl/cv32e40p_apu_responder_if.sv - shared-APU request/response bundle between core and APU
// Purpose: groups the APU request (req/gnt, operands, op, flags) and response
//          (rvalid, result, flags, busy) signals of the core's shared-APU port.
// Modports:
//   master - core side: drives request fields, observes gnt/response/busy
//   slave  - APU side:  observes request fields, drives gnt/response/busy
interface cv32e40p_apu_responder_if #(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5
);
  logic                                apu_req_i;
  logic                                apu_gnt_o;
  logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_i;
  logic [APU_WOP_CPU-1:0]              apu_op_i;
  logic [APU_NDSFLAGS_CPU-1:0]         apu_flags_i;
  logic                                apu_rvalid_o;
  logic [31:0]                         apu_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]         apu_flags_o;
  logic                                busy_o;

  modport master (
    output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o, busy_o
  );

  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o, busy_o
  );
endinterface

// File: rtl/cv32e40p_apu_responder.sv
// rtl/cv32e40p_apu_responder.sv - APU responder: pipelined integer ops plus 32-step restoring divider
// Purpose: accepts APU requests from the core EX stage and returns each result on a
//          one-cycle rvalid pulse. ADD/SUB/MUL/MAC/MIN/MAX and undefined ops go through a
//          LATENCY-deep pipeline; DIVU/REMU run on an iterative divider (33-cycle latency).
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset; drops every in-flight op
//   apu    slave modport of cv32e40p_apu_responder_if
//          (req/gnt, operands a/b/c, op, flags in; rvalid/result/flags out; busy)
//   Response flags are {illegal, divz, ovf, neg, zero} in bits 4..0.
module cv32e40p_apu_responder #(
  parameter int LATENCY          = 2,
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5
) (
  input logic                     clk_i,
  input logic                     rst_i,
  cv32e40p_apu_responder_if.slave apu
);

  localparam logic [APU_WOP_CPU-1:0] OP_ADD  = APU_WOP_CPU'(0);
  localparam logic [APU_WOP_CPU-1:0] OP_SUB  = APU_WOP_CPU'(1);
  localparam logic [APU_WOP_CPU-1:0] OP_MUL  = APU_WOP_CPU'(2);
  localparam logic [APU_WOP_CPU-1:0] OP_MAC  = APU_WOP_CPU'(3);
  localparam logic [APU_WOP_CPU-1:0] OP_MIN  = APU_WOP_CPU'(4);
  localparam logic [APU_WOP_CPU-1:0] OP_MAX  = APU_WOP_CPU'(5);
  localparam logic [APU_WOP_CPU-1:0] OP_DIVU = APU_WOP_CPU'(6);
  localparam logic [APU_WOP_CPU-1:0] OP_REMU = APU_WOP_CPU'(7);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t       r_state;
  logic [5:0]   r_count;
  logic [31:0]  r_quo;      // dividend shifting out / quotient shifting in
  logic [31:0]  r_rem;
  logic [31:0]  r_div_b;
  logic         r_op_rem;

  logic [LATENCY-1:0] r_pv;
  logic [31:0]        r_pres   [LATENCY];
  logic [4:0]         r_pflags [LATENCY];

  logic [31:0] w_a, w_b, w_c, w_prod, w_res;
  logic        w_ovf, w_illegal, w_is_div;
  logic [4:0]  w_flags;
  logic        w_inflight, w_gnt, w_pipe_load;

  logic [32:0] w_rem_sh, w_diff;
  logic        w_step_ok;

  logic [31:0] w_div_res;
  logic [4:0]  w_div_flags;
  logic        w_out_rvalid;
  logic [31:0] w_out_res;
  logic [4:0]  w_out_flags;

  logic        w_unused;
  assign w_unused = ^apu.apu_flags_i;

  // Combinational ALU for the pipelined ops, evaluated on the request in the grant cycle.
  always_comb begin
    w_a       = apu.apu_operands_i[0];
    w_b       = apu.apu_operands_i[1];
    w_c       = apu.apu_operands_i[2];
    w_prod    = w_a * w_b;
    w_res     = '0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    w_is_div  = (apu.apu_op_i == OP_DIVU) || (apu.apu_op_i == OP_REMU);
    case (apu.apu_op_i)
      OP_ADD: begin
        w_res = w_a + w_b;
        w_ovf = (w_a[31] == w_b[31]) && (w_res[31] != w_a[31]);
      end
      OP_SUB: begin
        w_res = w_a - w_b;
        w_ovf = (w_a[31] != w_b[31]) && (w_res[31] != w_a[31]);
      end
      OP_MUL:  w_res = w_prod;
      OP_MAC:  w_res = w_prod + w_c;
      OP_MIN:  w_res = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
      OP_MAX:  w_res = ($signed(w_a) > $signed(w_b)) ? w_a : w_b;
      OP_DIVU, OP_REMU: w_res = '0;
      default: w_illegal = 1'b1;
    endcase
    w_flags = {w_illegal, 1'b0, w_ovf, w_res[31], (w_res == 32'd0)};
  end

  // The last pipeline stage is the output register, so an op sitting there has already
  // been delivered this cycle; only the earlier stages hold a divide off.
  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      w_inflight = w_inflight | r_pv[i];
    end
    w_gnt = 1'b0;
    if (r_state == S_IDLE && apu.apu_req_i) begin
      w_gnt = w_is_div ? !w_inflight : 1'b1;
    end
    w_pipe_load = w_gnt && !w_is_div;
  end

  // Invalid slots carry zero data so the output reads 0 whenever nothing is returned.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pv <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pres[i]   <= '0;
        r_pflags[i] <= '0;
      end
    end else begin
      r_pv[0]     <= w_pipe_load;
      r_pres[0]   <= w_pipe_load ? w_res : 32'd0;
      r_pflags[0] <= w_pipe_load ? w_flags : 5'd0;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i]     <= r_pv[i-1];
        r_pres[i]   <= r_pres[i-1];
        r_pflags[i] <= r_pflags[i-1];
      end
    end
  end

  // Restoring division step: shift next dividend bit into the partial remainder and
  // subtract the divisor when it fits. With b==0 every step "fits", yielding all-ones
  // quotient and the dividend as remainder.
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[31]};
    w_diff    = w_rem_sh - {1'b0, r_div_b};
    w_step_ok = !w_diff[32];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div_b  <= '0;
      r_op_rem <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt && w_is_div) begin
            r_quo    <= w_a;
            r_rem    <= '0;
            r_div_b  <= w_b;
            r_op_rem <= (apu.apu_op_i == OP_REMU);
            r_count  <= 6'd32;
            r_state  <= S_DIV;
          end
        end
        S_DIV: begin
          r_quo   <= {r_quo[30:0], w_step_ok};
          r_rem   <= w_step_ok ? w_diff[31:0] : w_rem_sh[31:0];
          r_count <= r_count - 6'd1;
          if (r_count == 6'd1) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A divide-by-zero result is a sentinel rather than an arithmetic value, so it reports
  // only divz and not zero/neg.
  always_comb begin
    w_div_res   = r_op_rem ? r_rem : r_quo;
    w_div_flags = (r_div_b == 32'd0) ? 5'b01000
                                     : {3'b000, w_div_res[31], (w_div_res == 32'd0)};
    if (r_state == S_DONE) begin
      w_out_rvalid = 1'b1;
      w_out_res    = w_div_res;
      w_out_flags  = w_div_flags;
    end else begin
      w_out_rvalid = r_pv[LATENCY-1];
      w_out_res    = r_pres[LATENCY-1];
      w_out_flags  = r_pflags[LATENCY-1];
    end
  end

  assign apu.apu_gnt_o    = w_gnt;
  assign apu.apu_rvalid_o = w_out_rvalid;
  assign apu.apu_result_o = w_out_res;
  assign apu.apu_flags_o  = APU_NUSFLAGS_CPU'(w_out_flags);
  assign apu.busy_o       = (|r_pv) || (r_state != S_IDLE);

endmodule
